// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO in front of it.
// Frames are start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbg_state
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = 4;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // Handshake: a word moves on any rising edge where s_valid && s_ready;
  // s_ready depends only on the FIFO fill level, never on s_valid.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, pop, have;
  logic [DATA_BITS-1:0] head;

  assign s_ready    = (count != (AW+1)'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign have       = (count != '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  state_t               state, state_n;
  logic [BCW-1:0]       baud_cnt, baud_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_q, par_n;
  logic                 tx_q, tx_n;
  logic                 busy_q;
  logic                 bit_end, load;

  assign bit_end   = (baud_cnt == BCW'(CPB - 1));
  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      par_q    <= par_n;
      tx_q     <= tx_n;
      busy_q   <= (state_n != ST_IDLE);
    end
  end

  // tx_n is the line level for the next bit, so tx changes exactly on bit boundaries.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_q;
    tx_n    = tx_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
        load = have;
      end
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          tx_n    = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_n = '0;
            if (PARITY != 0) begin
              state_n = ST_PARITY;
              tx_n    = par_q;
            end else begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n   = bit_cnt + 1'b1;
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n = ST_STOP;
          tx_n    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_n = '0;
            if (have) load = 1'b1;
            else      state_n = ST_IDLE;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (state != ST_IDLE) baud_n = bit_end ? '0 : baud_cnt + 1'b1;
    // Back-to-back frames reuse this path from STOP, so there is no idle gap.
    if (load) begin
      pop     = 1'b1;
      state_n = ST_START;
      baud_n  = '0;
      bit_n   = '0;
      shreg_n = head;
      par_n   = (^head) ^ (PARITY == 2);
      tx_n    = 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: several parameter sets share one stimulus stream and
// each is compared every cycle with a frame-level model of the line.
module tb_uart_tx_fifo;
  localparam int NCFG = 5;
  localparam int CLKF  [NCFG] = '{16, 16, 16, 53, 9};
  localparam int BAUD  [NCFG] = '{1, 1, 1, 10, 3};
  localparam int DBITS [NCFG] = '{8, 8, 8, 7, 9};
  localparam int PAR   [NCFG] = '{0, 1, 2, 0, 2};
  localparam int STOPB [NCFG] = '{1, 1, 1, 2, 2};
  localparam int DEPTH [NCFG] = '{4, 4, 4, 8, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [8:0] s_data = '0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  logic [NCFG-1:0] tx_v, busy_v, ready_v, idle_v;
  int              cnt_v [NCFG];
  int              st_v  [NCFG];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int g, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0d expected %0d (cycle %0d)", g, name, act, exp, cyc);
    end
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int CPB  = CLKF[g] / BAUD[g];
    localparam int DB   = DBITS[g];
    localparam int CW   = $clog2(DEPTH[g]) + 1;
    localparam int MASK = (1 << DB) - 1;

    logic          dut_tx, dut_busy, dut_ready;
    logic [CW-1:0] dut_cnt;
    logic [2:0]    dut_state;

    uart_tx_fifo #(
      .CLK_FREQ(CLKF[g]), .BAUD_RATE(BAUD[g]), .DATA_BITS(DB),
      .PARITY(PAR[g]), .STOP_BITS(STOPB[g]), .FIFO_DEPTH(DEPTH[g])
    ) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data[DB-1:0]),
      .s_ready(dut_ready), .tx(dut_tx), .tx_busy(dut_busy),
      .fifo_count(dut_cnt), .dbg_state(dut_state)
    );

    assign tx_v[g]    = dut_tx;
    assign busy_v[g]  = dut_busy;
    assign ready_v[g] = dut_ready;
    assign idle_v[g]  = !dut_busy && (dut_cnt == '0);
    assign cnt_v[g]   = int'(dut_cnt);
    assign st_v[g]    = int'(dut_state);

    // model: queue of accepted words plus the list of line bits of the frame in flight
    int mq[$];
    bit frame[$];
    bit active = 1'b0;
    int elapsed = 0;
    bit do_push, start_next;

    function automatic void load_frame(int w);
      frame.delete();
      frame.push_back(1'b0);
      for (int i = 0; i < DB; i++) frame.push_back(bit'((w >> i) & 1));
      if (PAR[g] != 0) frame.push_back(bit'(($countones(w) % 2) ^ (PAR[g] == 2 ? 1 : 0)));
      for (int i = 0; i < STOPB[g]; i++) frame.push_back(1'b1);
    endfunction

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mq.delete();
        frame.delete();
        active  = 1'b0;
        elapsed = 0;
      end else begin
        do_push    = s_valid && (mq.size() != DEPTH[g]);
        start_next = 1'b0;
        if (!active) start_next = (mq.size() != 0);
        else if (elapsed == frame.size() * CPB - 1) begin
          start_next = (mq.size() != 0);
          active     = start_next;
        end else elapsed++;
        if (start_next) begin
          load_frame(mq.pop_front());
          active  = 1'b1;
          elapsed = 0;
        end
        if (do_push) mq.push_back(int'(s_data) & MASK);
      end
    end

    // scoreboard compare, every cycle
    always @(negedge clk) begin
      check("tx", g, int'(dut_tx), active ? int'(frame[elapsed / CPB]) : 1);
      check("tx_busy", g, int'(dut_busy), int'(active));
      check("fifo_count", g, int'(dut_cnt), mq.size());
      check("s_ready", g, int'(dut_ready), int'(mq.size() != DEPTH[g]));
    end
  end

  // driver tasks
  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic burst(int n, int first, output int base);
    @(negedge clk);
    base = cyc + 1;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 9'(first + i);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((idle_v != '1) && (n < bound));
    check("idle_timeout", 0, int'(idle_v == '1), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int burst_left;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 0, int'(tx_v[0]), 1);
    check("rst_busy", 0, int'(busy_v[0]), 0);
    check("rst_count", 0, cnt_v[0], 0);
    check("rst_ready", 0, int'(ready_v[0]), 1);
    check("rst_state", 0, st_v[0], 0);
    #1 rst = 1'b0;

    // single 0x55 frame: frame cycle k is sampled at cyc == b+1+k
    burst(1, 9'h055, b);
    wait_cyc(b + 1);       check("f55_start0", 0, int'(tx_v[0]), 0);
    wait_cyc(b + 1 + 15);  check("f55_start15", 0, int'(tx_v[0]), 0);
    wait_cyc(b + 1 + 16);  check("f55_bit0", 0, int'(tx_v[0]), 1);
    wait_cyc(b + 1 + 32);  check("f55_bit1", 0, int'(tx_v[0]), 0);
    wait_cyc(b + 1 + 128); check("f55_bit7", 0, int'(tx_v[0]), 0);
    wait_cyc(b + 1 + 144); check("f55_stop", 0, int'(tx_v[0]), 1);
    wait_cyc(b + 1 + 159); check("f55_busy_last", 0, int'(busy_v[0]), 1);
    wait_cyc(b + 1 + 160); check("f55_busy_end", 0, int'(busy_v[0]), 0);
    wait_idle(2000);

    // three back-to-back frames with no gap
    burst(3, 9'h001, b);
    wait_cyc(b + 1 + 159); check("b2b_stop1", 0, int'(tx_v[0]), 1);
    wait_cyc(b + 1 + 160); check("b2b_start2", 0, int'(tx_v[0]), 0);
    check("b2b_busy160", 0, int'(busy_v[0]), 1);
    wait_cyc(b + 1 + 192); check("b2b_f2_bit1", 0, int'(tx_v[0]), 1);
    wait_cyc(b + 1 + 320); check("b2b_start3", 0, int'(tx_v[0]), 0);
    wait_cyc(b + 1 + 479); check("b2b_busy479", 0, int'(busy_v[0]), 1);
    wait_cyc(b + 1 + 480); check("b2b_busy480", 0, int'(busy_v[0]), 0);
    wait_idle(2000);

    // six words into a 4-deep FIFO, one cycle apart
    burst(6, 9'h0A0, b);
    wait_cyc(b + 4);
    check("ovf_count", 0, cnt_v[0], 4);
    check("ovf_ready", 0, int'(ready_v[0]), 0);
    check("ovf_count_d2", 4, cnt_v[4], 2);
    wait_cyc(b + 5);       check("ovf_count_after", 0, cnt_v[0], 4);
    wait_idle(3000);

    // parity even / odd on 0x07
    burst(1, 9'h007, b);
    wait_cyc(b + 1 + 152);
    check("par_even", 1, int'(tx_v[1]), 1);
    check("par_odd", 2, int'(tx_v[2]), 0);
    wait_cyc(b + 1 + 175); check("par_busy175", 1, int'(busy_v[1]), 1);
    wait_cyc(b + 1 + 176); check("par_busy176", 1, int'(busy_v[1]), 0);
    wait_idle(2000);

    // 7 data bits, 2 stop bits, 5 clocks per bit
    burst(1, 9'h07F, b);
    wait_cyc(b + 1 + 2);   check("d7_start", 3, int'(tx_v[3]), 0);
    wait_cyc(b + 1 + 5);   check("d7_bit0", 3, int'(tx_v[3]), 1);
    wait_cyc(b + 1 + 44);  check("d7_stop1", 3, int'(tx_v[3]), 1);
    wait_cyc(b + 1 + 49);  check("d7_busy49", 3, int'(busy_v[3]), 1);
    wait_cyc(b + 1 + 50);  check("d7_busy50", 3, int'(busy_v[3]), 0);
    wait_idle(2000);

    // reset in the middle of data bit 3 with two words waiting
    burst(3, 9'h0C3, b);
    wait_cyc(b + 1 + 72);
    check("mid_count_pre", 0, cnt_v[0], 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx", 0, int'(tx_v[0]), 1);
    check("mid_rst_busy", 0, int'(busy_v[0]), 0);
    check("mid_rst_count", 0, cnt_v[0], 0);
    check("mid_rst_ready", 0, int'(ready_v[0]), 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (400) @(negedge clk);
    check("post_rst_busy", 0, int'(busy_v[0]), 0);
    check("post_rst_tx", 0, int'(tx_v[0]), 1);

    // random traffic: sparse single writes plus occasional bursts
    burst_left = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (burst_left == 0 && $urandom_range(0, 299) == 0) burst_left = $urandom_range(2, 10);
      if (burst_left > 0) begin
        s_valid = 1'b1;
        burst_left--;
      end else begin
        s_valid = ($urandom_range(0, 39) == 0);
      end
      s_data = 9'($urandom_range(0, 511));
    end
    @(negedge clk);
    s_valid = 1'b0;
    wait_idle(5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
